spm_ext_mem_port: RTL and testbench

//  Parametrised memory and external-load port for the stored-program machine (SPM) core.

---
 rtl/spm_pkg.sv | 16 +
 rtl/spm_sync.sv | 27 ++
 rtl/spm_ext_mem_port.sv | 155 +++++++++++++++
 tb/tb_spm_ext_mem_port.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// spm_pkg: shared types and default sizes for the SPM memory/external-load port.
//   spm_state_e : arbitration FSM states (IDLE, EXT_WR, HOLD)
//   SPM_DW      : default data word width
//   SPM_AW      : default address width (DEPTH = 2**AW)
package spm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXT_WR = 2'd1,
        HOLD   = 2'd2
    } spm_state_e;

    localparam int unsigned SPM_DW = 8;
    localparam int unsigned SPM_AW = 8;

endpackage

// File: rtl/spm_sync.sv
// spm_sync: single-bit N-stage synchroniser with asynchronous active-low reset.
//   clk : destination clock
//   rst : asynchronous active-low reset, clears every stage
//   d   : asynchronous input
//   q   : synchronised output (STAGES clk edges of latency)
module spm_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spm_ext_mem_port.sv
// spm_ext_mem_port: DEPTH-word RAM shared between pad loading and the SPM core.
//   clk, rst    : clock, asynchronous active-low reset
//   ext_write   : async pad strobe, each rising edge requests one write
//   ext_auto    : 1 = write at internal pointer, 0 = write at ext_addr
//   ext_addr    : pad address (write target and readback address)
//   ext_data    : pad write data
//   ext_wrap    : sticky flag, auto pointer wrapped DEPTH-1 -> 0
//   cpu_req/we/addr/wdata : core access request
//   cpu_ready   : core request accepted when cpu_req & cpu_ready
//   cpu_rdata   : read data, valid with cpu_rvalid
//   cpu_rvalid  : one-cycle pulse after an accepted read
//   memory_bus  : registered readback of mem[ext_addr]
//   io_oeb      : output-enable bar for memory_bus pads
module spm_ext_mem_port
    import spm_pkg::*;
#(
    parameter int unsigned DW          = SPM_DW,
    parameter int unsigned AW          = SPM_AW,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ext_write,
    input  logic          ext_auto,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_data,
    output logic          ext_wrap,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ready,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic [DW-1:0] memory_bus,
    output logic [DW-1:0] io_oeb
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    spm_state_e    state, state_next;
    logic          write_sync, write_prev, write_edge;
    logic          auto_sync, auto_prev, auto_fall;
    logic [AW-1:0] ptr;
    logic [AW-1:0] waddr;
    logic          ext_we;
    logic          fsm_ready;
    logic          cpu_rd, cpu_wr;

    spm_sync #(.STAGES(SYNC_STAGES)) u_sync_write (
        .clk (clk),
        .rst (rst),
        .d   (ext_write),
        .q   (write_sync)
    );

    spm_sync #(.STAGES(SYNC_STAGES)) u_sync_auto (
        .clk (clk),
        .rst (rst),
        .d   (ext_auto),
        .q   (auto_sync)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_prev <= 1'b0;
            auto_prev  <= 1'b0;
        end else begin
            write_prev <= write_sync;
            auto_prev  <= auto_sync;
        end
    end

    assign write_edge = write_sync & ~write_prev;
    assign auto_fall  = ~auto_sync & auto_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // HOLD gives the core one guaranteed ready cycle between back-to-back pad writes.
    always_comb begin
        state_next = state;
        fsm_ready  = 1'b1;
        case (state)
            IDLE: begin
                if (write_edge) state_next = EXT_WR;
            end
            EXT_WR: begin
                fsm_ready  = 1'b0;
                state_next = write_edge ? HOLD : IDLE;
            end
            HOLD: begin
                state_next = EXT_WR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cpu_ready = fsm_ready & rst;
    assign ext_we    = (state == EXT_WR);
    assign waddr     = auto_sync ? ptr : ext_addr;
    assign cpu_rd    = cpu_req & cpu_ready & ~cpu_we;
    assign cpu_wr    = cpu_req & cpu_ready & cpu_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            ext_wrap <= 1'b0;
        end else if (auto_fall) begin
            ptr <= '0;
        end else if (ext_we && auto_sync) begin
            ptr <= ptr + 1'b1;
            if (ptr == '1) ext_wrap <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io_oeb <= '1;
        end else begin
            io_oeb <= '0;
        end
    end

    // Single write port: EXT_WR deasserts cpu_ready, so the two sources never collide.
    always_ff @(posedge clk) begin
        if (ext_we) begin
            mem[waddr] <= ext_data;
        end else if (cpu_wr) begin
            mem[cpu_addr] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
            memory_bus <= '0;
        end else begin
            cpu_rvalid <= cpu_rd;
            if (cpu_rd) cpu_rdata <= mem[cpu_addr];
            memory_bus <= mem[ext_addr];
        end
    end

endmodule

// File: tb/tb_spm_ext_mem_port.sv
// tb_spm_ext_mem_port: self-checking bench for spm_ext_mem_port.
module tb_spm_ext_mem_port;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ext_write = 1'b0;
    logic       ext_auto = 1'b0;
    logic [7:0] ext_addr = '0;
    logic [7:0] ext_data = '0;
    logic       ext_wrap;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic       cpu_ready;
    logic [7:0] cpu_rdata;
    logic       cpu_rvalid;
    logic [7:0] memory_bus;
    logic [7:0] io_oeb;

    spm_ext_mem_port #(.DW(8), .AW(8), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .rst        (rst),
        .ext_write  (ext_write),
        .ext_auto   (ext_auto),
        .ext_addr   (ext_addr),
        .ext_data   (ext_data),
        .ext_wrap   (ext_wrap),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .memory_bus (memory_bus),
        .io_oeb     (io_oeb)
    );

    always #5 clk = ~clk;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] model [256];
    int         ptr_m = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;   // write data, or expected read data
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read scoreboard: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && cpu_rvalid) begin
            if (exp_q.size() == 0) begin
                check("rvalid_spurious", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, mon_exp});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic strobe(input logic [7:0] addr, input logic [7:0] data);
        ext_addr  = addr;
        ext_data  = data;
        ext_write = 1'b1;
        repeat (SS + 3) tick();
        ext_write = 1'b0;
        repeat (4) tick();
        if (ext_auto) begin
            model[ptr_m] = data;
            ptr_m = (ptr_m + 1) % 256;
        end else begin
            model[addr] = data;
        end
    endtask

    task automatic set_auto(input logic v);
        if (ext_auto && !v) ptr_m = 0;
        ext_auto = v;
        repeat (SS + 3) tick();
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [7:0] exp);
        int waitc = 0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = a;
        while (!cpu_ready && waitc < 50) begin
            tick();
            waitc++;
        end
        if (!cpu_ready) begin
            check("read_ready_timeout", 32'd0, 32'd1);
            cpu_req = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        tick();
        cpu_req = 1'b0;
        check("rvalid_next_cycle", {31'd0, cpu_rvalid}, 32'd1);
        tick();
        check("rvalid_pulse", {31'd0, cpu_rvalid}, 32'd0);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        int waitc = 0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        while (!cpu_ready && waitc < 50) begin
            tick();
            waitc++;
        end
        if (!cpu_ready) begin
            check("write_ready_timeout", 32'd0, 32'd1);
        end else begin
            tick();
            model[a] = d;
        end
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    task automatic read_burst(input int start, input int count);
        int i = 0;
        int guard = 0;
        logic [7:0] a;
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        while (i < count && guard < count * 4 + 50) begin
            a = 8'(start + i);
            cpu_addr = a;
            if (cpu_ready) begin
                exp_q.push_back(model[a]);
                i++;
            end
            tick();
            guard++;
        end
        cpu_req = 1'b0;
        tick();
        tick();
        check("burst_accepted", i, count);
    endtask

    initial begin
        int         stalls;
        int         acc;
        logic [7:0] a;
        logic [7:0] old;

        tbl[0] = '{1'b1, 8'h20, 8'h11};
        tbl[1] = '{1'b1, 8'h21, 8'h22};
        tbl[2] = '{1'b1, 8'hFF, 8'hEE};
        tbl[3] = '{1'b1, 8'h00, 8'h01};
        tbl[4] = '{1'b0, 8'h20, 8'h11};
        tbl[5] = '{1'b0, 8'h21, 8'h22};
        tbl[6] = '{1'b0, 8'hFF, 8'hEE};
        tbl[7] = '{1'b0, 8'h00, 8'h01};
        tbl[8] = '{1'b1, 8'h20, 8'h33};
        tbl[9] = '{1'b0, 8'h20, 8'h33};

        // Reset
        repeat (3) tick();
        check("rst_io_oeb", {24'd0, io_oeb}, 32'hFF);
        check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        check("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
        check("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        check("rst_memory_bus", {24'd0, memory_bus}, 32'd0);
        check("rst_ext_wrap", {31'd0, ext_wrap}, 32'd0);
        rst = 1'b1;
        check("oeb_before_edge", {24'd0, io_oeb}, 32'hFF);
        tick();
        check("oeb_after_release", {24'd0, io_oeb}, 32'h00);
        check("ready_after_release", {31'd0, cpu_ready}, 32'd1);
        repeat (3) tick();

        // Manual load
        strobe(8'h10, 8'hA5);
        check("manual_memory_bus", {24'd0, memory_bus}, 32'hA5);
        cpu_read(8'h10, 8'hA5);

        // Core port vector table
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].we) cpu_write(tbl[i].addr, tbl[i].data);
            else cpu_read(tbl[i].addr, tbl[i].data);
        end

        // Auto load of every address
        set_auto(1'b1);
        for (int i = 0; i < 256; i++) begin
            strobe(8'h00, 8'(i));
            if (i == 254) check("wrap_before_last", {31'd0, ext_wrap}, 32'd0);
        end
        check("wrap_after_256", {31'd0, ext_wrap}, 32'd1);
        read_burst(0, 256);
        strobe(8'h00, 8'h77);
        cpu_read(8'h00, 8'h77);
        cpu_read(8'h01, 8'h01);
        check("wrap_sticky", {31'd0, ext_wrap}, 32'd1);

        // Contention: back-to-back reads while a pad write lands
        set_auto(1'b0);
        ext_addr = 8'hF0;
        ext_data = 8'h5A;
        stalls = 0;
        acc = 0;
        a = 8'h01;
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (c == 2) ext_write = 1'b1;
            if (c == 8) ext_write = 1'b0;
            cpu_addr = a;
            if (cpu_ready) begin
                exp_q.push_back(model[a]);
                a++;
                acc++;
            end else begin
                stalls++;
            end
            tick();
        end
        cpu_req = 1'b0;
        model[8'hF0] = 8'h5A;
        tick();
        tick();
        check("contention_stalls", stalls, 1);
        check("contention_accepted", acc, 23);
        check("contention_drained", exp_q.size(), 0);
        cpu_read(8'hF0, 8'h5A);

        // Strobe-to-RAM latency observed through readback
        ext_addr = 8'h20;
        ext_data = 8'hC3;
        tick();
        tick();
        check("lat_old_before", {24'd0, memory_bus}, {24'd0, model[8'h20]});
        ext_write = 1'b1;
        repeat (SS + 2) tick();
        check("lat_old_at_write", {24'd0, memory_bus}, {24'd0, model[8'h20]});
        tick();
        check("lat_new_after", {24'd0, memory_bus}, 32'hC3);
        ext_write = 1'b0;
        repeat (4) tick();
        model[8'h20] = 8'hC3;

        // Readback ordering against a core write
        ext_addr = 8'h40;
        tick();
        tick();
        old = model[8'h40];
        check("rb_initial", {24'd0, memory_bus}, {24'd0, old});
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 8'h40;
        cpu_wdata = 8'h3C;
        check("rb_ready", {31'd0, cpu_ready}, 32'd1);
        tick();
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        model[8'h40] = 8'h3C;
        check("rb_old_one_cycle", {24'd0, memory_bus}, {24'd0, old});
        tick();
        check("rb_new", {24'd0, memory_bus}, 32'h3C);

        // Reset during an in-flight auto write
        set_auto(1'b1);
        strobe(8'h00, 8'h99);
        ext_data = 8'hDE;
        ext_write = 1'b1;
        repeat (SS + 1) tick();
        check("midwr_stalled", {31'd0, cpu_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("midwr_rst_ready", {31'd0, cpu_ready}, 32'd0);
        ext_write = 1'b0;
        repeat (3) tick();
        check("midwr_rst_oeb", {24'd0, io_oeb}, 32'hFF);
        rst = 1'b1;
        ptr_m = 0;
        tick();
        check("midwr_wrap_cleared", {31'd0, ext_wrap}, 32'd0);
        check("midwr_rdata_cleared", {24'd0, cpu_rdata}, 32'd0);
        repeat (SS + 3) tick();
        cpu_read(8'h01, 8'h01);
        strobe(8'h00, 8'hB2);
        cpu_read(8'h00, 8'hB2);
        cpu_read(8'h01, 8'h01);

        repeat (4) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
